fifo_wr_arbiter: RTL

- Write-side controller for the depth-8 asynchronous FIFO.
- Shares the single FIFO write port between NUM_REQ requesters using round-robin arbitration.
- Owns the write pointer: binary address plus Gray pointer sent to the read domain.
- Generates the registered full flag from the Gray read pointer after it has been brought into the write domain by the two-flop r2w synchronizer.

---
 rtl/fifo_wr_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin shared write port, write pointer and full flag for the depth-8 async FIFO; WR_ALMOST_FULL_EN adds w_almost_full
module fifo_wr_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                           w_clk,
  input  logic                           w_rstn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic [ADDR_WIDTH:0]            rq2_point,
  output logic [ADDR_WIDTH:0]            w_point,
  output logic [ADDR_WIDTH-1:0]          w_addr,
  output logic                           w_en,
  output logic [DATA_WIDTH-1:0]          w_data,
`ifdef WR_ALMOST_FULL_EN
  output logic                           w_almost_full,
`endif
  output logic                           w_full
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0]       last, gidx;
  logic [ADDR_WIDTH:0] bin, bnext, gnext;
  logic                found;
  int                  idx;
  // search starts just after the last winner; nothing is granted while full or in reset
  always_comb begin
    gnt = '0;
    gidx = last;
    w_data = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++)
        if (!found && w_rstn && !w_full && req[i] && i == idx) begin
          found = 1'b1;
          gnt[i] = 1'b1;
          gidx = IW'(i);
          w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end
  end
  assign w_en   = |gnt;
  assign w_addr = bin[ADDR_WIDTH-1:0];
  assign bnext  = bin + (ADDR_WIDTH+1)'(w_en);
  assign gnext  = bnext ^ (bnext >> 1);
  always_ff @(posedge w_clk or negedge w_rstn)
    if (!w_rstn) begin
      bin     <= '0;
      w_point <= '0;
      w_full  <= 1'b0;
      last    <= IW'(NUM_REQ - 1);
    end else begin
      bin     <= bnext;
      w_point <= gnext;
      w_full  <= gnext == {~rq2_point[ADDR_WIDTH:ADDR_WIDTH-1], rq2_point[ADDR_WIDTH-2:0]};
      if (w_en) last <= gidx;
    end
`ifdef WR_ALMOST_FULL_EN
  logic [ADDR_WIDTH:0] rbin, fill;
  always_comb begin
    rbin = '0;
    for (int j = 0; j <= ADDR_WIDTH; j++) rbin[j] = ^(rq2_point >> j);
  end
  assign fill = bnext - rbin;
  always_ff @(posedge w_clk or negedge w_rstn)
    if (!w_rstn) w_almost_full <= 1'b0;
    else w_almost_full <= fill >= {1'b0, {ADDR_WIDTH{1'b1}}};
`endif
endmodule
